// File: rtl/wport_arbiter_if.sv
// rtl/wport_arbiter_if.sv - request/grant and write-port bundle for the register-file write arbiter
interface wport_arbiter_if #(
  parameter int n = 32
);
  logic [3:0]   req;
  logic [4:0]   addr0;
  logic [4:0]   addr1;
  logic [4:0]   addr2;
  logic [4:0]   addr3;
  logic [n-1:0] data0;
  logic [n-1:0] data1;
  logic [n-1:0] data2;
  logic [n-1:0] data3;
  logic [3:0]   ack;
  logic [31:0]  we;
  logic [n-1:0] wdata;
  logic [1:0]   grant_id;
  logic         busy;

  modport master (
    output req, addr0, addr1, addr2, addr3, data0, data1, data2, data3,
    input  ack, we, wdata, grant_id, busy
  );

  modport slave (
    input  req, addr0, addr1, addr2, addr3, data0, data1, data2, data3,
    output ack, we, wdata, grant_id, busy
  );
endinterface

// File: rtl/wport_arbiter.sv
// rtl/wport_arbiter.sv - 4-way arbiter for a 32-entry register-file write port; WPORT_ARB_RR_EN selects round-robin over fixed priority
module wport_arbiter #(
  parameter int n = 32
) (
  input logic            clk,
  input logic            reset_n,
  wport_arbiter_if.slave bus
);
  logic [3:0]   ack_q;
  logic [31:0]  we_q;
  logic [n-1:0] wdata_q;
  logic [1:0]   gid_q;

  logic [3:0]   elig;
  logic [1:0]   win;
  logic         win_valid;
  logic [4:0]   win_addr;
  logic [n-1:0] win_data;

`ifdef WPORT_ARB_RR_EN
  logic [1:0]   ptr;
`endif

  always_comb begin
    // a requester acked this cycle is still holding req; it must not win twice
    elig      = bus.req & ~ack_q;
    win_valid = |elig;
    win       = '0;
`ifdef WPORT_ARB_RR_EN
    for (int k = 3; k >= 0; k--) begin
      if (elig[ptr + 2'(k)]) win = ptr + 2'(k);
    end
`else
    for (int k = 3; k >= 0; k--) begin
      if (elig[k]) win = 2'(k);
    end
`endif
    case (win)
      2'd0:    begin win_addr = bus.addr0; win_data = bus.data0; end
      2'd1:    begin win_addr = bus.addr1; win_data = bus.data1; end
      2'd2:    begin win_addr = bus.addr2; win_data = bus.data2; end
      default: begin win_addr = bus.addr3; win_data = bus.data3; end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q   <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      gid_q   <= '0;
`ifdef WPORT_ARB_RR_EN
      ptr     <= '0;
`endif
    end else begin
      ack_q <= win_valid ? (4'b0001 << win) : 4'b0000;
      // register 0 is read-only: the write is acked but never enabled
      we_q  <= (win_valid && win_addr != 5'd0) ? (32'd1 << win_addr) : 32'd0;
      if (win_valid) begin
        wdata_q <= win_data;
        gid_q   <= win;
`ifdef WPORT_ARB_RR_EN
        ptr     <= win + 2'd1;
`endif
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.we       = we_q;
  assign bus.wdata    = wdata_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = |(elig & ~(4'b0001 << win));
endmodule

// File: doc/wport_arbiter.md
WPORT_ARBITER -- requirements
Module: wport_arbiter

Interface
REQ-001 Parameter: n, default 32, data width of the shared register-file write port.
REQ-002 Ports (clock and reset first); reset is asynchronous and active-low:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester write request, bit i for requester i.
- addr0..addr3  input  5 each  target register index of requester i.
- data0..data3  input  n each  write data of requester i.
- ack  output  4  one-cycle grant/completion pulse, one-hot or zero.
- we  output  32  one-hot enable vector, bit k drives the enable of register k.
- wdata  output  n  shared write data to all 32 registers.
- grant_id  output  2  index of the requester served by the current we/ack.
- busy  output  1  high when any req is pending and was not served this cycle.

Function
REQ-003 Arbitration occurs every cycle; eligible = req AND NOT ack (a requester acked this cycle is excluded).
REQ-004 The winner is registered; ack[w], we, wdata and grant_id update on the next posedge (latency 1) and hold for exactly one cycle.
REQ-005 Requester i holds req[i], addr_i and data_i stable from assertion until the cycle ack[i] is high, and either drops req[i] or presents a new request the following cycle.
REQ-006 wdata = data of the winner; we = one-hot decode of the winner's addr; zero eligible requesters -> ack = 0, we = 0, wdata and grant_id hold their previous value.
REQ-007 Address 0 is read-only: a write to addr 0 is acknowledged normally but we stays all-zero that cycle.
REQ-008 At most one ack bit and at most one we bit are high in any cycle.
REQ-009 A priority pointer ptr[1:0] selects the search start; the search order is ptr, ptr+1, ptr+2, ptr+3 mod 4 (wrap 3 -> 0).
REQ-010 After a grant to w, ptr <= w+1 mod 4; with no grant, ptr holds.
REQ-011 busy is combinational: busy = |(req AND NOT ack) after excluding the requester chosen this cycle.
REQ-012 With all four requesting continuously, each requester is granted once in every 4 consecutive grants (round-robin build).
REQ-013 A new req arriving in the same cycle as another requester's ack competes normally in that cycle.

Reset
REQ-014 reset_n low asynchronously forces ack = 0, we = 0, wdata = 0, grant_id = 0 and ptr = 0, independent of clk.
REQ-015 A request pending during reset is not served; after reset_n rises, arbitration resumes on the first posedge from ptr = 0.
REQ-016 Reset asserted in the same cycle as a registered grant cancels that grant; no we pulse reaches the registers.

Configuration
REQ-017 Macro WPORT_ARB_RR_EN: when defined, round-robin per REQ-009/010/012.
REQ-018 When WPORT_ARB_RR_EN is undefined, fixed priority applies: requester 0 highest, 3 lowest; ptr is absent, and all other requirements are unchanged (REQ-012 is not required).

Verification
REQ-019 Reset: reset_n=0 mid-cycle with req=4'b1111 -> ack=0, we=0, wdata=0, grant_id=0 immediately.
REQ-020 Single write: req=4'b0100, addr2=7, data2=32'h0000_00AA -> next cycle ack=4'b0100, we=32'h0000_0080, wdata=32'hAA, grant_id=2, for one cycle.
REQ-021 Contention, RR build: req=4'b1111 held, re-requesting after each ack -> grant_id sequence 0,1,2,3,0,... with no repeat within 4 grants.
REQ-022 Contention, fixed build: req=4'b1010 held, re-requesting after each ack -> grants 1,3,1,3... (1 excluded only in its ack cycle).
REQ-023 Zero register: req=4'b0001, addr0=0, data0=32'hFFFF_FFFF -> ack=4'b0001, we=0.
REQ-024 Reset mid-operation: assert reset_n=0 while ack=4'b0010 -> ack and we drop immediately; after release with req=4'b0010 -> first grant is to 1 one cycle later, ptr restarted at 0.
